// File: rtl/booth_mult_seq.sv
// Purpose: iterative radix-4 modified-Booth multiplier, one Booth digit per clock, signed/unsigned per operation.
// Latency: o_valid rises N_DIG cycles after the accept edge; minimum issue interval is N_DIG+2 cycles.
// Backpressure: result is held stable in DONE until o_valid&i_ready; o_ready is high only in IDLE.
module booth_mult_seq #(
    parameter int WIDTH_DATA = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_signed,
    input  logic [WIDTH_DATA-1:0]     i_multiplicand,
    input  logic [WIDTH_DATA-1:0]     i_multiplier,
    input  logic                      i_abort,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [2*WIDTH_DATA-1:0]   o_data,
    output logic                      o_busy
);

    // Number of radix-4 digits: one extra digit covers the extension bit,
    // so unsigned operands are handled exactly.
    localparam int N_DIG = WIDTH_DATA / 2 + 1;
    // Accumulator carries two guard bits above the product width.
    localparam int W_ACC = 2 * WIDTH_DATA + 2;
    // Recoded multiplier: extended operand plus the implicit b[-1] and top extension.
    localparam int W_B   = 2 * N_DIG + 1;
    // Partial product before placement: wide enough for +/-2A of an extended operand.
    localparam int W_PP  = WIDTH_DATA + 2;
    localparam int W_CNT = $clog2(N_DIG + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [W_PP-1:0]        a_reg;     // multiplicand, sign/zero-extended at accept
    logic [W_B-1:0]         b_reg;     // recoded multiplier, shifted down two bits per digit
    logic [W_CNT-1:0]       cnt;       // digit index j
    logic [W_ACC-1:0]       acc;

    logic [2:0]             trip;
    logic [W_PP-1:0]        pp_mag;
    logic                   pp_neg;
    logic [W_PP-1:0]        pp;
    logic [W_ACC-1:0]       pp_ext;
    logic [W_ACC-1:0]       pp_sh;
    logic [W_ACC-1:0]       acc_nxt;
    logic [W_CNT:0]         shamt;

    logic                   a_ext;
    logic                   b_ext;

    // Extension bit for the incoming operands: sign bit in signed mode, zero otherwise.
    // The mode is captured implicitly through these extensions.
    always_comb begin
        a_ext = i_signed & i_multiplicand[WIDTH_DATA-1];
        b_ext = i_signed & i_multiplier[WIDTH_DATA-1];
    end

    // Booth digit selection and partial product for the current digit, placed at 2j.
    always_comb begin
        trip   = b_reg[2:0];
        pp_mag = '0;
        pp_neg = 1'b0;
        case (trip)
            3'b001, 3'b010: pp_mag = a_reg;
            3'b011:         pp_mag = a_reg << 1;
            3'b100: begin
                pp_mag = a_reg << 1;
                pp_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                pp_mag = a_reg;
                pp_neg = 1'b1;
            end
            default:        pp_mag = '0;
        endcase
        pp      = pp_neg ? (~pp_mag + 1'b1) : pp_mag;
        pp_ext  = {{(W_ACC - W_PP){pp[W_PP-1]}}, pp};
        shamt   = {cnt, 1'b0};
        pp_sh   = pp_ext << shamt;
        acc_nxt = acc + pp_sh;
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            acc     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // i_abort is ignored here: an accept with abort still proceeds.
                    if (i_valid) begin
                        a_reg   <= {{2{a_ext}}, i_multiplicand};
                        b_reg   <= {b_ext, b_ext, i_multiplier, 1'b0};
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= BUSY;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (i_abort) begin
                        // Cancel: previous o_data is deliberately kept.
                        state   <= IDLE;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        acc   <= acc_nxt;
                        b_reg <= b_reg >> 2;
                        cnt   <= cnt + 1'b1;
                        if (cnt == W_CNT'(N_DIG - 1)) begin
                            o_data  <= acc_nxt[2*WIDTH_DATA-1:0];
                            o_valid <= 1'b1;
                            o_busy  <= 1'b0;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Result is never dropped; o_ready returns only after the handshake.
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
